// File: rtl/processador_multiciclo.sv
// -----------------------------------------------------------------------------
// processador_multiciclo
//
// Multicycle processor core with 16-bit instructions and a parametrised data
// and PC width. Each instruction walks FETCH -> DECODE -> EXEC [-> WB]; MUL
// stays in EXEC for DATA_W cycles running a shift-add multiplier, and HALT
// parks the core until reset.
//
// Instruction format: op=[15:12] rc=[11:8] ra=[7:4] rb=[3:0]
//
// Parameters
//   DATA_W     datapath and register width (>= 8, LI needs 8 immediate bits)
//   PC_W       PC / instruction-address width (4..12)
//
// Ports
//   CLOCK_50   core clock, all state on the rising edge
//   reset      asynchronous, active-low; clears all state
//   imem_addr  instruction address (always equal to pc)
//   imem_data  instruction word from a synchronous-read ROM (1-cycle latency)
//   dbg_addr   register-file debug read index
//   dbg_data   combinational read of register dbg_addr (r0 reads 0)
//   pc         current PC
//   retire     one-cycle pulse in the last cycle of each instruction
//   halted     high once HALT has executed, until reset
// -----------------------------------------------------------------------------
module processador_multiciclo #(
  parameter int DATA_W = 16,
  parameter int PC_W   = 12
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  output logic [PC_W-1:0]   imem_addr,
  input  logic [15:0]       imem_data,
  input  logic [3:0]        dbg_addr,
  output logic [DATA_W-1:0] dbg_data,
  output logic [PC_W-1:0]   pc,
  output logic              retire,
  output logic              halted
);

  typedef enum logic [2:0] {
    FETCH,
    DECODE,
    EXEC,
    WB,
    HALT
  } stateType;

  typedef enum logic [3:0] {
    OP_ADD  = 4'h0,
    OP_SUB  = 4'h1,
    OP_AND  = 4'h2,
    OP_OR   = 4'h3,
    OP_XOR  = 4'h4,
    OP_SLT  = 4'h5,
    OP_ADDI = 4'h6,
    OP_LI   = 4'h7,
    OP_BEQ  = 4'h8,
    OP_BNE  = 4'h9,
    OP_JMP  = 4'hA,
    OP_MUL  = 4'hB,
    OP_NOP0 = 4'hC,
    OP_NOP1 = 4'hD,
    OP_NOP2 = 4'hE,
    OP_HALT = 4'hF
  } opcodeType;

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(DATA_W - 1);

  stateType          state, nextState;
  opcodeType         opcode;
  logic [15:0]       ir;
  logic [DATA_W-1:0] regA, regB, regC;
  logic [DATA_W-1:0] result;
  logic [DATA_W-1:0] aluOut;
  logic [CNT_W-1:0]  mulCount;
  logic [DATA_W-1:0] regFile [16];

  logic [DATA_W-1:0] readA, readB, readC;
  logic [PC_W-1:0]   pcPlusOne, pcBranch, pcTarget;
  logic signed [3:0] branchOffset;
  logic              pcLoad;
  logic              regWrite;
  logic [3:0]        wbIndex;

  assign opcode       = opcodeType'(ir[15:12]);
  assign wbIndex      = ir[11:8];
  assign branchOffset = ir[3:0];

  assign imem_addr = pc;
  assign halted    = (state == HALT);

  // PC arithmetic wraps naturally at PC_W bits. The signed size cast
  // sign-extends the 4-bit branch offset to the PC width.
  assign pcPlusOne = pc + 1'b1;
  assign pcBranch  = pcPlusOne + PC_W'(branchOffset);

  // Register reads happen in DECODE, before IR is loaded, so the fields come
  // straight from the ROM output.
  assign readA = (imem_data[7:4]  == 4'd0) ? '0 : regFile[imem_data[7:4]];
  assign readB = (imem_data[3:0]  == 4'd0) ? '0 : regFile[imem_data[3:0]];
  assign readC = (imem_data[11:8] == 4'd0) ? '0 : regFile[imem_data[11:8]];

  assign dbg_data = (dbg_addr == 4'd0) ? '0 : regFile[dbg_addr];

  // ---------------------------------------------------------------------------
  // Single-cycle ALU for everything except MUL
  // ---------------------------------------------------------------------------
  always_comb begin
    aluOut = '0;
    case (opcode)
      OP_ADD:  aluOut = regA + regB;
      OP_SUB:  aluOut = regA - regB;
      OP_AND:  aluOut = regA & regB;
      OP_OR:   aluOut = regA | regB;
      OP_XOR:  aluOut = regA ^ regB;
      OP_SLT:  aluOut = DATA_W'($signed(regA) < $signed(regB));
      OP_ADDI: aluOut = regA + DATA_W'(ir[3:0]);
      OP_LI:   aluOut = DATA_W'(ir[7:0]);
      default: aluOut = '0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  // NOTE: every sequential block uses non-blocking (<=) assignments so all
  // registers update together from values sampled before the edge.
  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      state <= FETCH;
    end else begin
      state <= nextState;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state and control outputs
  // ---------------------------------------------------------------------------
  // NOTE: every output of this block gets a default first, so no path through
  // the case statement can leave a signal unassigned and infer a latch.
  always_comb begin
    nextState = state;
    retire    = 1'b0;
    pcLoad    = 1'b0;
    regWrite  = 1'b0;
    pcTarget  = pcPlusOne;

    case (state)
      FETCH:  nextState = DECODE;
      DECODE: nextState = EXEC;

      EXEC: begin
        case (opcode)
          OP_BEQ, OP_BNE: begin
            nextState = FETCH;
            retire    = 1'b1;
            pcLoad    = 1'b1;
            if ((regC == regA) == (opcode == OP_BEQ)) begin
              pcTarget = pcBranch;
            end
          end
          OP_JMP: begin
            nextState = FETCH;
            retire    = 1'b1;
            pcLoad    = 1'b1;
            pcTarget  = ir[PC_W-1:0];
          end
          OP_NOP0, OP_NOP1, OP_NOP2: begin
            nextState = FETCH;
            retire    = 1'b1;
            pcLoad    = 1'b1;
          end
          OP_MUL: begin
            // The last partial product is added on the same edge that leaves
            // for WB, so the product is complete when WB writes it.
            if (mulCount == MUL_LAST) begin
              nextState = WB;
            end
          end
          // HALT is a 3-cycle instruction and retires in its EXEC cycle; the
          // HALT state itself never retires again.
          OP_HALT: begin
            nextState = HALT;
            retire    = 1'b1;
          end
          default: nextState = WB;
        endcase
      end

      WB: begin
        nextState = FETCH;
        retire    = 1'b1;
        pcLoad    = 1'b1;
        regWrite  = 1'b1;
      end

      HALT:    nextState = HALT;
      default: nextState = FETCH;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath registers: PC, IR, operand latches, result and MUL counter
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      pc       <= '0;
      ir       <= '0;
      regA     <= '0;
      regB     <= '0;
      regC     <= '0;
      result   <= '0;
      mulCount <= '0;
    end else begin
      case (state)
        DECODE: begin
          ir       <= imem_data;
          regA     <= readA;
          regB     <= readB;
          regC     <= readC;
          result   <= '0;
          mulCount <= '0;
        end
        EXEC: begin
          if (opcode == OP_MUL) begin
            // Shift-add: regA holds the multiplicand shifted left, regB the
            // multiplier shifted right; bit 0 of regB gates each add.
            if (regB[0]) begin
              result <= result + regA;
            end
            regA     <= regA << 1;
            regB     <= regB >> 1;
            mulCount <= mulCount + 1'b1;
          end else begin
            result <= aluOut;
          end
        end
        default: ;
      endcase

      if (pcLoad) begin
        pc <= pcTarget;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Register file: 16 x DATA_W, r0 hard-wired to zero
  // ---------------------------------------------------------------------------
  // NOTE: the register file must come out of reset all-zero, so it is built
  // from flops with a reset loop rather than a RAM macro without reset.
  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 16; i++) begin
        regFile[i] <= '0;
      end
    end else if (regWrite && (wbIndex != 4'd0)) begin
      regFile[wbIndex] <= result;
    end
  end

endmodule

// File: doc/processador_multiciclo.md
# processador_multiciclo

Parametrised multicycle 16-bit-instruction processor core, successor to the fixed-width single-block processor top. It has an explicit fetch/decode/execute/writeback FSM and a configurable data and PC width. It adds conditional branches (BEQ/BNE), an iterative shift-add multiplier, HALT and a register-file debug port. It drives an external synchronous-read instruction memory and contains its own register file, ALU and PC logic.

## Interface
- DATA_W, 16, datapath and register width (≥ 8)
- PC_W, 12, PC / instruction-address width (≤ 12)
- CLOCK_50  in  1  core clock, all state on rising edge
- reset  in  1  asynchronous, active-low; clears all state when 0
- imem_addr  out  PC_W  instruction address, equals PC
- imem_data  in  16  instruction word; valid one cycle after imem_addr is presented (synchronous ROM)
- dbg_addr  in  4  register-file debug read index
- dbg_data  out  DATA_W  combinational read of register dbg_addr (r0 reads 0)
- pc  out  PC_W  current PC
- retire  out  1  one-cycle pulse when an instruction completes
- halted  out  1  high once HALT executes; held until reset

## Operation
- Instruction fields: op=[15:12], rc=[11:8], ra=[7:4], rb=[3:0]. 16 registers; r0 always reads 0 and writes to it are discarded.
- FSM states: FETCH, DECODE, EXEC, WB, HALT.
  - FETCH: imem_addr=PC; go to DECODE.
  - DECODE: IR<=imem_data; A<=R[ra], B<=R[rb], C<=R[rc]; go to EXEC.
  - EXEC: compute result, then per opcode.
  - WB: write R[rc]; PC<=PC+1; retire=1; go to FETCH.
- Opcodes. All arithmetic wraps mod 2^DATA_W; immediates are zero-extended unless stated.
  - 0 ADD: rc=A+B.
  - 1 SUB: rc=A−B.
  - 2 AND, 3 OR, 4 XOR.
  - 5 SLT: rc=1 if A<B signed, else 0.
  - 6 ADDI: rc=A+rb field.
  - 7 LI: rc=IR[7:0].
  - 8 BEQ: if C==A, PC<=PC+1+sext(IR[3:0]); else PC<=PC+1.
  - 9 BNE: as BEQ with the condition inverted.
  - A JMP: PC<=IR[PC_W-1:0].
  - B MUL: rc=low DATA_W bits of A×B (unsigned).
  - F HALT: enter HALT, halted<=1.
  - C/D/E: NOP. PC<=PC+1, no register write, retire.
- Branch, JMP and NOP leave EXEC straight to FETCH with retire=1 and do not visit WB. PC arithmetic wraps mod 2^PC_W.
- MUL runs as an iterative shift-add inside EXEC: a DATA_W-cycle counter, one multiplier bit per cycle. It leaves for WB when the counter reaches DATA_W−1.
- HALT is absorbing: no fetch, PC frozen, retire=0. Only reset exits it.
- Register-file reads in DECODE observe any write from the preceding WB, because WB completes before the next FETCH.

## Timing
- Reset (reset=0, asynchronous) sets:
  - state=FETCH, PC=0, imem_addr=0.
  - retire=0, halted=0.
  - all registers, IR, A, B, C = 0.
- First FETCH occurs on the first rising edge after reset deasserts.
- Cycles per instruction:
  - ALU/ADDI/LI: 4 (FETCH, DECODE, EXEC, WB).
  - BEQ/BNE/JMP/NOP: 3.
  - MUL: 3+DATA_W (FETCH, DECODE, DATA_W EXEC cycles, WB).
  - HALT: 3, then halted=1 from the following cycle onward.
- retire pulses in the last cycle of each instruction: WB, or EXEC for 3-cycle instructions.
- Reset asserted mid-MUL or mid-instruction aborts immediately: no partial register write and no PC update.
- Branch offset −1 (IR[3:0]=F) gives target PC, a self-loop. PC=2^PC_W−1 followed by +1 wraps to 0.
- dbg_data is combinational; it reflects a WB write from the cycle after the write edge.

## Test plan
- Reset then LI r1,5; LI r2,7; ADD r3,r1,r2 -> r3=12; retire pulses every 4 cycles; pc=3 after 12 cycles.
- DATA_W=16, LI r1,0xFF; LI r2,0xFF; MUL r3,r1,r2 -> r3=0xFE01; MUL takes 19 cycles. Repeat with DATA_W=8 -> r3=0x01.
- LI r1,3; BEQ r1,r1,+2 at PC=1 -> next PC=4. BNE r1,r1,+2 -> next PC=PC+1. Both take 3 cycles.
- SUB r3,r0,r1 with r1=1 -> r3=0xFFFF. SLT r4,r3,r0 -> r4=1. LI r0,9 -> dbg_data(r0)=0.
- JMP 0xFFF with PC_W=12, then a NOP at 0xFFF -> pc wraps to 0. A HALT word at PC 0 -> halted=1 and pc stays 0 for 20+ cycles.
- Pull reset low during MUL EXEC cycle 5 -> pc=0, halted=0, retire=0 and the destination register stays 0; normal fetch resumes after release.
